// File: rtl/gb_wr_arbiter_if.sv
// Write-port bundle shared by NUM_REQ writers, the write arbiter and the global buffer.
// master drives beats and buffer backpressure; slave is the arbiter side.
interface gb_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int PE      = 16,
    parameter int ADDR_W  = 32
);
    localparam int DW    = PE * 8;
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DW-1:0]     req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      gb_ready;
    logic                      gb_wr_en;
    logic [ADDR_W-1:0]         gb_addr;
    logic [DW-1:0]             gb_data;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_last, req_addr, req_data, gb_ready,
        input  req_ready, gb_wr_en, gb_addr, gb_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data, gb_ready,
        output req_ready, gb_wr_en, gb_addr, gb_data, grant_id, busy
    );
endinterface

// File: rtl/gb_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single global-buffer write port.
// One registered output beat; a grant holds until its req_last beat is accepted.
//
// state  | meaning
// S_IDLE | no owner; pick next writer from rr_ptr (one arbitration cycle)
// S_LOCK | grant_id owns the port until its last beat is accepted
module gb_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PE      = 16,
    parameter int ADDR_W  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    gb_wr_arbiter_if.slave bus
);
    localparam int DW    = PE * 8;
    localparam int GID_W = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic [GID_W-1:0]   w_winner;
    logic [GID_W-1:0]   w_cand;
    int                 w_idx;
    logic               w_any;
    logic               w_out_free;
    logic               w_accept;
    logic               w_last;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [DW-1:0]      r_data;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DW-1:0]      w_sel_data;

    assign w_out_free = !r_wr_en || bus.gb_ready;
    assign w_sel_addr = bus.req_addr[int'(r_grant_id) * ADDR_W +: ADDR_W];
    assign w_sel_data = bus.req_data[int'(r_grant_id) * DW +: DW];

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx  = (int'(r_rr_ptr) + k) % NUM_REQ;
            w_cand = GID_W'(w_idx);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_LOCK;
            end
            S_LOCK: begin
                w_req_ready[r_grant_id] = w_out_free;
                w_accept = bus.req_valid[r_grant_id] && w_out_free;
                w_last   = w_accept && bus.req_last[r_grant_id];
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output slot: loads only on an accepted beat, holds while the buffer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else if (clr) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) r_grant_id <= w_winner;
            if (w_last) begin
                r_rr_ptr <= (int'(r_grant_id) == NUM_REQ - 1) ? '0 : r_grant_id + GID_W'(1);
            end
            if (w_accept) begin
                r_wr_en <= 1'b1;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
            end else if (bus.gb_ready) begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.gb_wr_en  = r_wr_en;
    assign bus.gb_addr   = r_addr;
    assign bus.gb_data   = r_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state == S_LOCK);
endmodule

// File: tb/tb_gb_wr_arbiter.sv
// Bench for gb_wr_arbiter: per-writer beat queues drive the bus, a transaction-level
// model (owner / pointer / slot) is compared every cycle, plus literal scenario checks.
module tb_gb_wr_arbiter;
    localparam int N  = 2;
    localparam int PE = 16;
    localparam int AW = 32;
    localparam int DW = PE * 8;

    typedef struct {
        int            who;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    gb_wr_arbiter_if #(.NUM_REQ(N), .PE(PE), .ADDR_W(AW)) bus ();

    gb_wr_arbiter #(.NUM_REQ(N), .PE(PE), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t         q[$];
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;
    logic [N-1:0]  acc = '0;
    int            m_owner, m_ptr, m_gid;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            clr_req = 0, rst_rel = 0, hold_low = 0;
    logic [AW-1:0] stall_addr = '1;
    int            stall_left = 0, stall_seen = 0, stall_bad = 0, wr_hi_cnt = 0;
    int            wlog_cyc[$];
    logic [AW-1:0] wlog_addr[$];
    int            glog[$];
    logic          prev_busy = 1'b0;

    function automatic logic [DW-1:0] mk_data(logic [AW-1:0] a);
        return {a, ~a, a + 32'h1111_1111, a ^ 32'h5A5A_5A5A};
    endfunction

    function automatic int head(int who);
        for (int j = 0; j < q.size(); j++) if (q[j].who == who) return j;
        return -1;
    endfunction

    function automatic logic [AW-1:0] laddr(int i);
        return (i < wlog_addr.size()) ? wlog_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int lcyc(int i);
        return (i < wlog_cyc.size()) ? wlog_cyc[i] : -1000;
    endfunction

    function automatic int gl(int i);
        return (i >= 0 && i < glog.size()) ? glog[i] : -1;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_beat(int who, logic [AW-1:0] a, logic l);
        beat_t b;
        b.who = who; b.addr = a; b.data = mk_data(a); b.last = l;
        q.push_back(b);
    endtask

    task automatic push_burst(int who, logic [AW-1:0] base, int n);
        for (int b = 0; b < n; b++) push_beat(who, base + AW'(b * 16), b == n - 1);
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_gid = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // Transaction view: who owns the port, whose turn is next, what sits in the slot.
    task automatic model_step();
        bit free, found;
        int idx;
        if (clr) model_reset();
        else begin
            free = !m_wr || bus.gb_ready;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && bus.req_valid[idx]) begin
                        found = 1; m_owner = idx; m_gid = idx;
                    end
                end
                if (bus.gb_ready) m_wr = 1'b0;
            end else if (bus.req_valid[m_owner] && free) begin
                m_wr   = 1'b1;
                m_addr = bus.req_addr[m_owner*AW +: AW];
                m_data = bus.req_data[m_owner*DW +: DW];
                if (bus.req_last[m_owner]) begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (bus.gb_ready) m_wr = 1'b0;
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_owner >= 0 && (!m_wr || bus.gb_ready)) exp_rdy[m_owner] = 1'b1;
        chk("gb_wr_en", bus.gb_wr_en, m_wr);
        if (m_wr) begin
            chk("gb_addr", bus.gb_addr, m_addr);
            chk("gb_data", bus.gb_data, m_data);
        end
        chk("busy", bus.busy, m_owner >= 0);
        chk("grant_id", bus.grant_id, m_gid);
        chk("req_ready", bus.req_ready, exp_rdy);
        if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
        prev_busy = bus.busy;
    endtask

    task automatic drive();
        int h;
        clr = clr_req; clr_req = 0;
        if (rst_rel) begin rst_n = 1'b1; rst_rel = 0; end
        if (hold_low) bus.gb_ready = 1'b0;
        else if (bus.gb_wr_en && bus.gb_addr == stall_addr && stall_left > 0) begin
            bus.gb_ready = 1'b0; stall_left--; stall_seen++;
        end else bus.gb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            h = head(i);
            if (h >= 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_last[i]  = q[h].last;
                bus.req_addr[i*AW +: AW] = q[h].addr;
                bus.req_data[i*DW +: DW] = q[h].data;
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic capture();
        for (int i = 0; i < N; i++) acc[i] = rst_n && !clr && bus.req_valid[i] && bus.req_ready[i];
        if (rst_n && !clr && bus.gb_wr_en) begin
            wr_hi_cnt++;
            if (bus.gb_ready) begin
                wlog_cyc.push_back(cyc);
                wlog_addr.push_back(bus.gb_addr);
            end else if (bus.req_ready != '0) stall_bad++;
        end
    endtask

    task automatic step();
        int h;
        @(negedge clk);
        cyc++;
        if (!rst_n) model_reset(); else model_step();
        for (int i = 0; i < N; i++) if (acc[i]) begin
            h = head(i);
            if (h >= 0) q.delete(h);
        end
        compare();
        drive();
        #1;
        capture();
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        do begin step(); n++; end
        while (!(q.size() == 0 && !bus.busy && !bus.gb_wr_en) && n < budget);
        chk(name, q.size() == 0 && !bus.busy && !bus.gb_wr_en, 1'b1);
    endtask

    task automatic wait_wr(string name);
        int n;
        n = 0;
        while (!bus.gb_wr_en && n < 10) begin step(); n++; end
        chk(name, bus.gb_wr_en, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c_start, k, g0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.gb_ready = 1'b1;
        model_reset();

        step(); step();
        chk("reset_wr_en", bus.gb_wr_en, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_addr", bus.gb_addr, '0);
        chk("reset_ready", bus.req_ready, '0);
        rst_rel = 1; step();

        // single writer, 4 beats
        n0 = wlog_addr.size(); c_start = cyc + 1;
        push_burst(0, 32'h0, 4);
        drain("t1_drain", 30);
        chk("t1_count", wlog_addr.size() - n0, 4);
        for (int b = 0; b < 4; b++) begin
            chk("t1_addr", laddr(n0 + b), 32'(b * 16));
            chk("t1_cycle", lcyc(n0 + b) - c_start, b + 2);
        end
        chk("t1_grant", gl(glog.size() - 1), 0);
        chk("t1_busy_low", bus.busy, 1'b0);

        // rr_ptr must now favour writer 1
        n0 = wlog_addr.size();
        push_beat(0, 32'h500, 1'b1); push_beat(1, 32'h1500, 1'b1);
        drain("probe_drain", 30);
        chk("probe_first", laddr(n0), 32'h1500);
        chk("probe_second", laddr(n0 + 1), 32'h500);
        chk("probe_grant", gl(glog.size() - 2), 1);

        clr_req = 1; step(); step();

        // contention: two 3-beat bursts per writer
        n0 = wlog_addr.size(); g0 = glog.size();
        push_burst(0, 32'h2000, 3); push_burst(1, 32'h3000, 3);
        push_burst(0, 32'h2100, 3); push_burst(1, 32'h3100, 3);
        drain("cont_drain", 80);
        for (int b = 0; b < 12; b++)
            chk("cont_addr", laddr(n0 + b),
                (((b / 3) % 2) ? 32'h3000 : 32'h2000) + 32'((b / 6) * 'h100) + 32'((b % 3) * 16));
        for (int b = 1; b < 12; b++)
            chk("cont_gap", lcyc(n0 + b) - lcyc(n0 + b - 1), (b % 3 == 0) ? 2 : 1);
        for (int g = 0; g < 4; g++) chk("cont_grant", gl(g0 + g), g % 2);

        // backpressure on beat 2
        n0 = wlog_addr.size();
        stall_addr = 32'h4010; stall_left = 3; stall_seen = 0; stall_bad = 0;
        push_burst(0, 32'h4000, 4);
        drain("bp_drain", 40);
        chk("bp_count", wlog_addr.size() - n0, 4);
        for (int b = 0; b < 4; b++) chk("bp_addr", laddr(n0 + b), 32'h4000 + 32'(b * 16));
        chk("bp_hold", lcyc(n0 + 1) - lcyc(n0), 4);
        chk("bp_resume", lcyc(n0 + 2) - lcyc(n0 + 1), 1);
        chk("bp_stall_seen", stall_seen, 3);
        chk("bp_ready_low", stall_bad, 0);
        stall_addr = '1;

        // owner gap while writer 1 waits
        n0 = wlog_addr.size();
        push_beat(0, 32'h5000, 1'b0);
        k = 0;
        while (head(0) >= 0 && k < 10) begin step(); k++; end
        chk("gap_first_accept", head(0), -1);
        push_beat(1, 32'h6000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gap_ready1", bus.req_ready[1], 1'b0);
            chk("gap_grant", bus.grant_id, 0);
            chk("gap_busy", bus.busy, 1'b1);
        end
        push_beat(0, 32'h5010, 1'b0); push_beat(0, 32'h5020, 1'b1);
        drain("gap_drain", 40);
        chk("gap_w0_b0", laddr(n0), 32'h5000);
        chk("gap_w0_b1", laddr(n0 + 1), 32'h5010);
        chk("gap_w0_b2", laddr(n0 + 2), 32'h5020);
        chk("gap_w1", laddr(n0 + 3), 32'h6000);

        // clr while writer 1 is locked and stalled
        push_beat(0, 32'h6100, 1'b1); drain("clr_prep", 20);
        hold_low = 1;
        push_burst(1, 32'h7000, 3);
        wait_wr("clr_pre_wr_en");
        chk("clr_pre_grant", bus.grant_id, 1);
        clr_req = 1; step();
        q.delete(); hold_low = 0;
        step();
        chk("clr_wr_en", bus.gb_wr_en, 1'b0);
        chk("clr_busy", bus.busy, 1'b0);
        chk("clr_grant", bus.grant_id, 0);
        chk("clr_addr", bus.gb_addr, '0);
        chk("clr_data", bus.gb_data, '0);
        n0 = wlog_addr.size();
        push_beat(0, 32'h8100, 1'b1); push_beat(1, 32'h8000, 1'b1);
        drain("clr_post_drain", 30);
        chk("clr_ptr_first", laddr(n0), 32'h8100);
        chk("clr_w1_granted", laddr(n0 + 1), 32'h8000);
        chk("clr_w1_grant_id", gl(glog.size() - 1), 1);

        // async reset mid-burst
        push_burst(1, 32'h9000, 3);
        wait_wr("rst_pre_wr_en");
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("rst_wr_en", bus.gb_wr_en, 1'b0);
        chk("rst_addr", bus.gb_addr, '0);
        chk("rst_data", bus.gb_data, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_ready", bus.req_ready, '0);
        q.delete();
        step(); step();
        rst_rel = 1; step();
        wr_hi_cnt = 0; n0 = wlog_addr.size();
        push_beat(0, 32'hA000, 1'b1);
        drain("rst_post_drain", 20);
        chk("rst_one_pulse", wr_hi_cnt, 1);
        chk("rst_one_write", wlog_addr.size() - n0, 1);
        chk("rst_write_addr", laddr(n0), 32'hA000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
